// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned IMEM_AW    = 6;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, control and instruction-RAM write port of the boot loader.
interface imem_loader_if #(
  parameter int unsigned N = 32
);
  import imem_loader_pkg::*;

  logic               start;
  logic [6:0]         len;
  logic               in_valid;
  logic [BYTE_W-1:0]  in_data;
  logic               in_ready;
  logic               we;
  logic [IMEM_AW-1:0] waddr;
  logic [N-1:0]       wdata;
  logic               done;
  logic               cpu_hold;

  modport master (
    input  start, len, in_valid, in_data,
    output in_ready, we, waddr, wdata, done, cpu_hold
  );

  modport slave (
    output start, len, in_valid, in_data,
    input  in_ready, we, waddr, wdata, done, cpu_hold
  );

endinterface

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into N-bit words; word_full flags the
// cycle whose accepted byte completes a word (word then holds it).
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [N-1:0]      word,
  output logic              word_full
);

  localparam int unsigned Bpw  = N / BYTE_W;
  localparam int unsigned CntW = (Bpw > 1) ? $clog2(Bpw) : 1;

  logic [N-1:0]    sr_q;
  logic [CntW-1:0] cnt_q;

  // New bytes enter at the top; after Bpw shifts the first byte sits in [7:0].
  assign word      = (sr_q >> BYTE_W) | (N'(byte_in) << (N - BYTE_W));
  assign word_full = shift_en && (cnt_q == CntW'(Bpw - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sr_q  <= word;
      cnt_q <= word_full ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: writes a streamed program into instruction RAM, zero-fills
// the remainder, then releases the CPU from hold.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = IMEM_DEPTH
) (
  input logic           clk,
  input logic           reset,
  imem_loader_if.master bus
);

  localparam int unsigned AW = IMEM_AW;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q;
  logic [6:0]     len_q;
  logic           we_q;
  logic [AW-1:0]  waddr_q;
  logic [N-1:0]   wdata_q;
  logic           hold_q;

  logic           in_ready;
  logic           shift_en;
  logic           start_ok;
  logic [6:0]     len_clamped;
  logic           last_word;
  logic           last_fill;
  logic [N-1:0]   word;
  logic           word_full;

  assign in_ready    = (state_q == LOAD);
  assign shift_en    = bus.in_valid && in_ready;
  assign start_ok    = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign len_clamped = (bus.len > 7'(DEPTH)) ? 7'(DEPTH) : bus.len;
  assign last_word   = ({1'b0, addr_q} == (len_q - 7'd1));
  assign last_fill   = (addr_q == AW'(DEPTH - 1));

  word_assembler #(
    .N (N)
  ) u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_ok),
    .shift_en  (shift_en),
    .byte_in   (bus.in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = (len_clamped == 7'd0) ? FILL : LOAD;
      LOAD:       if (word_full && last_word) begin
                    state_d = (len_q == 7'(DEPTH)) ? DONE : FILL;
                  end
      FILL:       if (last_fill) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      // Release hold only once DONE has already been presented for a cycle.
      hold_q  <= (state_q != DONE) || (state_d != DONE);
      we_q    <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            len_q  <= len_clamped;
            addr_q <= '0;
          end
        end
        LOAD: begin
          if (word_full) begin
            we_q    <= 1'b1;
            waddr_q <= addr_q;
            wdata_q <= word;
            // A full-depth load ends on the last address; hold it there.
            if (state_d != DONE) addr_q <= addr_q + 1'b1;
          end
        end
        FILL: begin
          we_q    <= 1'b1;
          waddr_q <= addr_q;
          wdata_q <= '0;
          if (!last_fill) addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.done     = (state_q == DONE);
  assign bus.cpu_hold = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus reset and
// restart sequences; RAM writes are checked against a scoreboard queue.
module tb_imem_loader;

  localparam int KLoad  = 0;
  localparam int KFillC = 1;  // fill write, must follow previous write back-to-back
  localparam int KFillX = 2;  // first fill write with an exactly known cycle

  typedef struct {
    logic [6:0]  len;
    int          eff;
    int          gap;
    bit          fill_start;
    logic [31:0] w0, w1, w2;
  } vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          kind;
  } wr_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  wr_t  wq[$];
  int   lq[$];
  int   last_we_cyc = 0;
  int   first_fill_cyc = 0;
  int   n_load = 0;
  int   n_fill = 0;

  imem_loader_if #(.N(32)) bus ();

  imem_loader #(
    .N     (32),
    .DEPTH (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Scoreboard: every write must match the next expected entry.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_we_addr", {58'd0, bus.waddr}, 64'hffff);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("waddr", {58'd0, bus.waddr}, {58'd0, e.addr});
        chk("wdata", {32'd0, bus.wdata}, {32'd0, e.data});
        chk("done_vs_last_write", {63'd0, bus.done}, {63'd0, (e.addr == 6'd63)});
        if (e.kind == KLoad) begin
          n_load++;
          if (lq.size() == 0) chk("load_latency_missing", 64'd0, 64'd1);
          else chk("load_latency", cyc, lq.pop_front());
        end else begin
          n_fill++;
          if (e.kind == KFillX) chk("first_fill_cycle", cyc, first_fill_cyc);
          else chk("fill_contiguous", cyc, last_we_cyc + 1);
        end
      end
      last_we_cyc = cyc;
    end
  end

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    if (i == 2) return v.w2;
    return {8'(i), 8'hc3, 8'(v.len), 8'(i * 7 + 1)};
  endfunction

  task automatic do_start(input logic [6:0] l, output int edge_idx);
    bus.start = 1'b1;
    bus.len   = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edge_idx  = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit last);
    logic rdy;
    int   guard;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    rdy   = 1'b0;
    while (!rdy && guard < 100) begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!rdy) chk("byte_accept_timeout", 64'd0, 64'd1);
    // The write appears in the cycle right after the handshake edge.
    if (last && rdy) lq.push_back(cyc);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    int         s_edge;
    int         k;
    bit         was_done;
    logic [31:0] wv;
    wr_t        e;
    was_done = bus.done;
    n_load = 0;
    n_fill = 0;
    for (int i = 0; i < 64; i++) begin
      e.addr = 6'(i);
      e.data = (i < v.eff) ? word_of(v, i) : 32'd0;
      e.kind = (i < v.eff) ? KLoad : ((i == 0) ? KFillX : KFillC);
      wq.push_back(e);
    end
    do_start(v.len, s_edge);
    first_fill_cyc = s_edge + 1;
    if (was_done) begin
      chk("restart_done_low", {63'd0, bus.done}, 64'd0);
      chk("restart_hold_high", {63'd0, bus.cpu_hold}, 64'd1);
    end
    for (int w = 0; w < v.eff; w++) begin
      wv = word_of(v, w);
      for (int b = 0; b < 4; b++) send_byte(wv[8*b +: 8], v.gap, b == 3);
    end
    if (v.fill_start) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.len   = 7'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    chk("done_seen", {63'd0, bus.done}, 64'd1);
    chk("hold_during_final_write", {63'd0, bus.cpu_hold}, 64'd1);
    @(negedge clk);
    chk("hold_released", {63'd0, bus.cpu_hold}, 64'd0);
    chk("we_low_in_done", {63'd0, bus.we}, 64'd0);
    chk("pending_writes", wq.size(), 64'd0);
    chk("load_write_count", n_load, v.eff);
    chk("fill_write_count", n_fill, 64 - v.eff);
    wq.delete();
    lq.delete();
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   dummy;

  initial begin
    tbl[0] = '{len: 7'd1,   eff: 1,  gap: 0, fill_start: 1'b0,
               w0: 32'hf8000001, w1: 32'h0, w2: 32'h0};
    tbl[1] = '{len: 7'd3,   eff: 3,  gap: 1, fill_start: 1'b1,
               w0: 32'hf8000001, w1: 32'hf8008002, w2: 32'h8b050083};
    tbl[2] = '{len: 7'd64,  eff: 64, gap: 0, fill_start: 1'b0,
               w0: 32'h12345678, w1: 32'h9abcdef0, w2: 32'h0badf00d};
    tbl[3] = '{len: 7'd0,   eff: 0,  gap: 0, fill_start: 1'b0,
               w0: 32'h0, w1: 32'h0, w2: 32'h0};
    tbl[4] = '{len: 7'd100, eff: 64, gap: 0, fill_start: 1'b0,
               w0: 32'hcafef00d, w1: 32'h00000013, w2: 32'hffffffff};
    tbl[5] = '{len: 7'd7,   eff: 7,  gap: 2, fill_start: 1'b1,
               w0: 32'h00a00093, w1: 32'h80000000, w2: 32'h00000001};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.len = 7'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    repeat (2) @(posedge clk);
    // start coincident with reset must be ignored
    #1 bus.start = 1'b1;
    bus.len = 7'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_we", {63'd0, bus.we}, 64'd0);
    chk("rst_waddr", {58'd0, bus.waddr}, 64'd0);
    chk("rst_wdata", {32'd0, bus.wdata}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hold", {63'd0, bus.cpu_hold}, 64'd1);
    reset = 1'b0;

    // Bytes offered in IDLE are not consumed.
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("idle_done", {63'd0, bus.done}, 64'd0);
    end
    bus.in_valid = 1'b0;

    foreach (tbl[i]) run_load(tbl[i]);

    // Reset in the middle of a word, then reload cleanly.
    do_start(7'd2, dummy);
    send_byte(8'h44, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_we", {63'd0, bus.we}, 64'd0);
    chk("midrst_hold", {63'd0, bus.cpu_hold}, 64'd1);
    chk("midrst_done", {63'd0, bus.done}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    rv = '{len: 7'd1, eff: 1, gap: 0, fill_start: 1'b0,
           w0: 32'hdeadbeef, w1: 32'h0, w2: 32'h0};
    run_load(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
